ct8_down: RTL and testbench
===========================

CT8_DOWN -- requirements
Module: ct8_down

Interface
REQ-001 SHALL have port clk_l  input  1  clock; all state updates occur on its falling edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port enable_l  input  1  active-low count enable.
REQ-004 SHALL have port load  input  1  synchronous parallel load strobe, active-high.
REQ-005 SHALL have port data  input  8  parallel load value.
REQ-006 SHALL have port count  output  8  current counter value, registered.
REQ-007 SHALL have port borrow_out  output  1  high while count == 8'h00, combinational from count only.
REQ-008 SHALL have port done  output  1  sticky underflow flag, registered.
REQ-009 SHALL have port nib_borrow  output  1  low-nibble borrow, high while count[3:0] == 4'h0; provided for cascading.
REQ-010 Clock and reset are fixed: one clock; reset is asynchronous and active-high.

Function
REQ-011 SHALL give priority at each falling edge of clk_l as: load, then count (enable_l low), then hold.
REQ-012 SHALL, on load, set count to data, clear done, and capture data into an internal 8-bit reload register, with 1-edge latency.
REQ-013 SHALL, with enable_l low and load low, decrement count by 1 per falling edge, as two 4-bit slices.
REQ-014 SHALL decrement the high nibble only on edges where the low nibble is 4'h0 (nib_borrow high) and enable_l is low.
REQ-015 SHALL, on an enabled edge with count == 8'h00 (underflow), set done to 1 and set count per REQ-023/REQ-024.
REQ-016 SHALL keep done at 1 until the next load or reset; further underflows leave it at 1.
REQ-017 SHALL hold count and done unchanged with enable_l high and load low.
REQ-018 SHALL give load priority on an edge where load and an underflow coincide: count = data and done = 0.
REQ-019 SHALL update borrow_out and nib_borrow with no clock latency when count changes; enable_l does not gate them.
REQ-020 SHALL apply 8-bit modulo arithmetic, with no X or carry propagation beyond bit 7.

Reset
REQ-021 SHALL, when reset is high, force immediately and independent of clk_l: count = 8'h00, done = 0, reload register = 8'h00.
REQ-022 SHALL keep the values of REQ-021 while reset is high, ignore load and enable_l, and resume at the first falling edge after reset falls; after reset borrow_out = 1 and nib_borrow = 1.

Configuration
REQ-023 SHALL, with CT8_DOWN_RELOAD_EN defined, load count from the reload register on underflow (periodic divide-by-(N+1) timer).
REQ-024 SHALL, without CT8_DOWN_RELOAD_EN, wrap count to 8'hFF on underflow; the reload register is not built and all other behaviour is identical.

Verification
REQ-025 Reset then no enable: reset pulse 5 ns, enable_l=1 for 10 edges -> count=00, borrow_out=1, done=0 throughout.
REQ-026 Load and count: load data=8'h12 one edge, then enable_l=0 -> count 12,11,10,0F (high nibble steps only at the 10->0F edge), nib_borrow high at 10.
REQ-027 Underflow: load 8'h02, enable_l=0 -> 02,01,00 (borrow_out=1), then FF with done=1 (no macro) or 02 with done=1 (macro defined); periodic 02,01,00,02.
REQ-028 Simultaneous load and underflow: count=00, enable_l=0, load=1 with data=8'h55 -> count=55, done=0.
REQ-029 Async reset mid-count: count=37, enable_l=0, reset asserted between clock edges -> count=00 and done=0 before the next edge; counting resumes from 00 (next FF, done=1) after release.
REQ-030 Hold: count=40, enable_l=1 for 5 edges -> count stays 40; load with enable_l=1 still loads.

Source files
------------

// File: rtl/ct8_down.sv
// ct8_down: 8-bit down counter built as two cascaded 4-bit slices, with a
// sticky underflow flag and borrow outputs for cascading. All state updates
// on the falling edge of clk_l. Reset is asynchronous and active-high.
//
// Optional feature (macro CT8_DOWN_RELOAD_EN):
//   defined   - on underflow the count reloads from the last loaded value,
//               giving a periodic divide-by-(N+1) timer.
//   undefined - on underflow the count wraps to 8'hFF; no reload register.
//
// Ports:
//   clk_l      in   1  clock, active on the falling edge
//   reset      in   1  asynchronous reset, active-high
//   enable_l   in   1  count enable, active-low
//   load       in   1  synchronous parallel load strobe, active-high
//   data       in   8  parallel load value
//   count      out  8  current counter value (registered)
//   borrow_out out  1  high while count == 8'h00 (combinational from count)
//   done       out  1  sticky underflow flag (registered)
//   nib_borrow out  1  high while count[3:0] == 4'h0 (combinational from count)

module ct8_down (
    input  logic       clk_l,
    input  logic       reset,
    input  logic       enable_l,
    input  logic       load,
    input  logic [7:0] data,
    output logic [7:0] count,
    output logic       borrow_out,
    output logic       done,
    output logic       nib_borrow
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned NIB_W = 4;

    logic [NIB_W-1:0] lo_dec;
    logic [NIB_W-1:0] hi_dec;
    logic [CNT_W-1:0] wrap_val;
    logic [CNT_W-1:0] count_nxt;
    logic             done_nxt;

`ifdef CT8_DOWN_RELOAD_EN
    logic [CNT_W-1:0] reload_q;

    // Reload value tracks the most recent parallel load.
    always_ff @(negedge clk_l or posedge reset) begin
        if (reset) begin
            reload_q <= '0;
        end else if (load) begin
            reload_q <= data;
        end
    end

    assign wrap_val = reload_q;
`else
    assign wrap_val = {CNT_W{1'b1}};
`endif

    // Borrow flags follow count directly so a cascaded stage sees them
    // without an extra edge of latency.
    assign nib_borrow = (count[NIB_W-1:0] == '0);
    assign borrow_out = (count == '0);

    // Slice decrement: low nibble always steps, high nibble steps only
    // when the low nibble is about to borrow.
    always_comb begin
        lo_dec = count[NIB_W-1:0] - NIB_W'(1);
        hi_dec = count[CNT_W-1:NIB_W];
        if (nib_borrow) begin
            hi_dec = count[CNT_W-1:NIB_W] - NIB_W'(1);
        end
    end

    // Next state: load beats count beats hold.
    always_comb begin
        count_nxt = count;
        done_nxt  = done;
        if (load) begin
            count_nxt = data;
            done_nxt  = 1'b0;
        end else if (!enable_l) begin
            if (borrow_out) begin
                count_nxt = wrap_val;
                done_nxt  = 1'b1;
            end else begin
                count_nxt = {hi_dec, lo_dec};
            end
        end
    end

    // Counter and sticky flag registers.
    always_ff @(negedge clk_l or posedge reset) begin
        if (reset) begin
            count <= '0;
            done  <= 1'b0;
        end else begin
            count <= count_nxt;
            done  <= done_nxt;
        end
    end

endmodule

// File: tb/tb_ct8_down.sv
// Scoreboard bench for ct8_down: stimulus pushes the expected post-edge state
// computed by an arithmetic model; an independent monitor pops and compares.

module tb_ct8_down;

    logic       clk_l;
    logic       reset;
    logic       enable_l;
    logic       load;
    logic [7:0] data;
    logic [7:0] count;
    logic       borrow_out;
    logic       done;
    logic       nib_borrow;

    ct8_down dut (
        .clk_l      (clk_l),
        .reset      (reset),
        .enable_l   (enable_l),
        .load       (load),
        .data       (data),
        .count      (count),
        .borrow_out (borrow_out),
        .done       (done),
        .nib_borrow (nib_borrow)
    );

    typedef struct packed {
        logic [7:0] c;
        logic       d;
        logic       b;
        logic       n;
    } exp_t;

    exp_t q[$];
    event reset_chk;
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 0;

    // Reference model state (plain integers).
    int m_count = 0;
    int m_done  = 0;
    int m_reload = 0;

    initial begin
        clk_l = 1'b0;
        forever #5 clk_l = ~clk_l;
    end

    function automatic void model_step(input bit rst, input bit en_l, input bit ld, input int d);
        if (rst) begin
            m_count = 0; m_done = 0; m_reload = 0;
        end else if (ld) begin
            m_count = d; m_done = 0; m_reload = d;
        end else if (!en_l) begin
            if (m_count == 0) begin
                m_done = 1;
`ifdef CT8_DOWN_RELOAD_EN
                m_count = m_reload;
`else
                m_count = 255;
`endif
            end else begin
                m_count = m_count - 1;
            end
        end
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.c = 8'(m_count);
        e.d = (m_done != 0);
        e.b = (m_count == 0);
        e.n = ((m_count % 16) == 0);
        q.push_back(e);
    endfunction

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    // One falling edge with the given inputs applied between edges.
    task automatic drive(input bit rst, input bit en_l, input bit ld, input logic [7:0] d);
        @(posedge clk_l);
        #1;
        reset = rst; enable_l = en_l; load = ld; data = d;
        model_step(rst, en_l, ld, int'(d));
        push_exp();
    endtask

    // Reset pulse between edges: check immediate effect, then one edge.
    task automatic async_pulse(input bit en_l, input bit ld, input logic [7:0] d);
        @(posedge clk_l);
        #1;
        reset = 1'b1;
        model_step(1'b1, 1'b0, 1'b0, 0);
        push_exp();
        -> reset_chk;
        #2;
        reset = 1'b0; enable_l = en_l; load = ld; data = d;
        model_step(1'b0, en_l, ld, int'(d));
        push_exp();
    endtask

    // Monitor: after each falling edge or mid-cycle reset, compare one entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_l or reset_chk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                check("count", int'(count), int'(e.c));
                check("done", int'(done), int'(e.d));
                check("borrow_out", int'(borrow_out), int'(e.b));
                check("nib_borrow", int'(nib_borrow), int'(e.n));
            end
        end
    end

    initial begin
        reset = 1'b1; enable_l = 1'b1; load = 1'b0; data = 8'h00;
        #1;
        model_step(1'b1, 1'b1, 1'b0, 0);
        push_exp();
        -> reset_chk;
        #4;
        reset = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b0, 8'h00);

        // Load and count across the nibble borrow.
        drive(1'b0, 1'b1, 1'b1, 8'h12);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 8'h00);

        // Underflow and sticky done.
        drive(1'b0, 1'b1, 1'b1, 8'h02);
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b0, 1'b0, 8'h00);

        // Load coinciding with underflow.
        drive(1'b0, 1'b1, 1'b1, 8'h00);
        drive(1'b0, 1'b0, 1'b1, 8'h55);
        drive(1'b0, 1'b0, 1'b0, 8'h00);

        // Async reset mid-count, resume from zero.
        drive(1'b0, 1'b1, 1'b1, 8'h37);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        async_pulse(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 8'h00);

        // Reset held across edges ignores load and enable.
        drive(1'b1, 1'b0, 1'b1, 8'hA5);
        drive(1'b1, 1'b0, 1'b1, 8'h5A);
        drive(1'b0, 1'b0, 1'b0, 8'h00);

        // Hold, then load while disabled.
        drive(1'b0, 1'b1, 1'b1, 8'h40);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 1'b1, 8'h9A);
        drive(1'b0, 1'b0, 1'b0, 8'h00);

        // Randomized traffic biased toward small loads to reach underflow.
        for (int i = 0; i < 600; i++) begin
            int unsigned r;
            logic [7:0]  d;
            bit          en_l;
            bit          ld;
            r    = $urandom_range(0, 59);
            en_l = ($urandom_range(0, 3) == 0);
            ld   = ($urandom_range(0, 11) == 0);
            d    = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 5)) : 8'($urandom_range(0, 255));
            if (r == 0) begin
                async_pulse(en_l, ld, d);
            end else if (r == 1) begin
                drive(1'b1, en_l, ld, d);
            end else begin
                drive(1'b0, en_l, ld, d);
            end
        end

        @(posedge clk_l);
        #2;
        check("queue_drained", q.size(), 0);
        stim_done = 1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
